// File: rtl/serial_bus_pkg.sv
// Shared types and constants for the single-wire serial bus.
// The parity helper is common to the master and the slaves.
package serial_bus_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_START,
        ST_ADDR,
        ST_DATA,
        ST_PAR,
        ST_STOP,
        ST_WAIT_RSP,
        ST_RSP,
        ST_RETRY_CHK,
        ST_DONE_OK,
        ST_DONE_FAIL
    } state_t;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

    localparam logic RSP_ACK = 1'b1;
    localparam logic RSP_NAK = 1'b0;

    localparam int PAR_MAX_W = 64;

    // Even parity: the returned bit makes the total count of ones even.
    function automatic logic even_parity(
        input logic [PAR_MAX_W-1:0] v
    );
        return ^v;
    endfunction

endpackage

// File: rtl/serial_bit_tick.sv
// Bit-period counter producing bit-end and mid-bit strobes.
// Restarting aligns the period to a frame or response start.
module serial_bit_tick #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic restart,
    input  logic en,
    output logic bit_end,
    output logic mid
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] MID  = CW'((CLKS_PER_BIT - 1) / 2);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (restart) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

    assign bit_end = en && (cnt == LAST);
    assign mid     = en && (cnt == MID);

endmodule

// File: rtl/serial_bus_master.sv
// Serial bus master: frames one addressed write, awaits the slave status.
// Define SERIAL_BUS_MASTER_RETRY_EN to retry NAKs/timeouts up to MAX_RETRY times.
module serial_bus_master
    import serial_bus_pkg::*;
#(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 16,
    parameter int CLKS_PER_BIT = 4,
    parameter int TIMEOUT      = 64,
    parameter int MAX_RETRY    = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cs,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    output logic              ready,
    output logic              serial_o,
    input  logic              serial_i,
    output logic              ok,
    output logic              fail,
    output logic              check_err,
    output logic              no_answer
);

    localparam int FW = ADDR_W + DATA_W;
    localparam int BW = $clog2(FW + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    state_t state;
    state_t next_state;

    logic [FW-1:0] frame_q;
    logic [FW-1:0] shift_q;
    logic          par_q;
    logic [BW-1:0] bcnt;
    logic [TW-1:0] tcnt;
    logic          phase_q;
    logic          nak_q;
    logic          ready_q;
    logic          rx_s1;
    logic          rx_s2;
    logic          rx;
    logic          accept;
    logic          retry_ok;
    logic          restart;
    logic          bit_end;
    logic          mid;
    logic          shifting;

    assign rx       = rx_s2;
    assign accept   = (state == ST_IDLE) && req_valid && ready_q;
    assign shifting = (state == ST_ADDR) || (state == ST_DATA);

    // Realign the bit counter whenever a frame or a response begins.
    assign restart = (next_state != state) &&
                     ((next_state == ST_START) ||
                      (next_state == ST_RSP));

    serial_bit_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tick (
        .clk    (clk),
        .reset_n(reset_n),
        .restart(restart),
        .en     (state != ST_IDLE),
        .bit_end(bit_end),
        .mid    (mid)
    );

`ifdef SERIAL_BUS_MASTER_RETRY_EN
    localparam int AW = $clog2(MAX_RETRY + 2);

    logic [AW-1:0] attempts;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            attempts <= '0;
        end else if (accept) begin
            attempts <= AW'(1);
        end else if ((state == ST_RETRY_CHK) && retry_ok) begin
            attempts <= attempts + 1'b1;
        end
    end

    assign retry_ok = (attempts < AW'(MAX_RETRY + 1));
`else
    logic unused_max_retry;

    assign unused_max_retry = ^MAX_RETRY;
    assign retry_ok         = 1'b0;
`endif

    always_comb begin
        next_state = state;
        unique case (state)
            ST_IDLE: begin
                if (accept) next_state = ST_START;
            end
            ST_START: begin
                if (bit_end) next_state = ST_ADDR;
            end
            ST_ADDR: begin
                if (bit_end && (bcnt == BW'(ADDR_W - 1)))
                    next_state = ST_DATA;
            end
            ST_DATA: begin
                if (bit_end && (bcnt == BW'(FW - 1)))
                    next_state = ST_PAR;
            end
            ST_PAR: begin
                if (bit_end) next_state = ST_STOP;
            end
            ST_STOP: begin
                if (bit_end) next_state = ST_WAIT_RSP;
            end
            ST_WAIT_RSP: begin
                if (rx == START_BIT)
                    next_state = ST_RSP;
                else if (tcnt == TW'(TIMEOUT - 1))
                    next_state = ST_RETRY_CHK;
            end
            ST_RSP: begin
                // Status is sampled mid-way through the bit after the start bit.
                if (phase_q && mid)
                    next_state = (rx == RSP_ACK) ? ST_DONE_OK
                                                 : ST_RETRY_CHK;
            end
            ST_RETRY_CHK: begin
                next_state = retry_ok ? ST_START : ST_DONE_FAIL;
            end
            ST_DONE_OK: begin
                next_state = ST_IDLE;
            end
            ST_DONE_FAIL: begin
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            ready_q <= 1'b0;
        end else begin
            state   <= next_state;
            ready_q <= (next_state == ST_IDLE) && cs;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_s1 <= IDLE_LEVEL;
            rx_s2 <= IDLE_LEVEL;
        end else begin
            rx_s1 <= serial_i;
            rx_s2 <= rx_s1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_q <= '0;
            par_q   <= 1'b0;
        end else if (accept) begin
            frame_q <= {req_addr, req_data};
            par_q   <= even_parity(PAR_MAX_W'({req_addr, req_data}));
        end
    end

    // The shifter reloads during every START, so retries resend the latched frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shift_q <= '0;
            bcnt    <= '0;
        end else if (state == ST_START) begin
            shift_q <= frame_q;
            bcnt    <= '0;
        end else if (shifting && bit_end) begin
            shift_q <= {shift_q[FW-2:0], 1'b0};
            bcnt    <= bcnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tcnt    <= '0;
            phase_q <= 1'b0;
            nak_q   <= 1'b0;
        end else begin
            tcnt <= (state == ST_WAIT_RSP) ? tcnt + 1'b1 : '0;
            if (state != ST_RSP)
                phase_q <= 1'b0;
            else if (bit_end)
                phase_q <= 1'b1;
            if (next_state == ST_RETRY_CHK)
                nak_q <= (state == ST_RSP) && (rx == RSP_NAK);
        end
    end

    always_comb begin
        serial_o = IDLE_LEVEL;
        unique case (state)
            ST_START: serial_o = START_BIT;
            ST_ADDR:  serial_o = shift_q[FW-1];
            ST_DATA:  serial_o = shift_q[FW-1];
            ST_PAR:   serial_o = par_q;
            ST_STOP:  serial_o = STOP_BIT;
            default:  serial_o = IDLE_LEVEL;
        endcase
    end

    assign ready     = ready_q;
    assign ok        = (state == ST_DONE_OK);
    assign fail      = (state == ST_DONE_FAIL);
    assign check_err = fail && nak_q;
    assign no_answer = fail && !nak_q;

endmodule

// File: doc/serial_bus_master.md
# serial_bus_master

Parametrised master for the single-wire serial bus. It accepts one addressed write request at a time from a local host through a valid/ready handshake and serialises it as a frame onto the bus. It then waits for the addressed slave's response and reports ok, fail, parity-NAK or no-answer. On a NAK or a timeout it retries a bounded number of times. It replaces the fixed-width master; slaves and the memory feeder sit around it unchanged in role.

## Interface
Parameters:
- ADDR_W, 8, slave address width.
- DATA_W, 16, payload width.
- CLKS_PER_BIT, 4, clk cycles per serial bit (≥2).
- TIMEOUT, 64, cycles to wait for a response start bit.
- MAX_RETRY, 2, extra attempts after a first failed attempt.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cs  in  1  chip select; gates request acceptance only.
- req_valid  in  1  host request present.
- req_addr  in  ADDR_W  target slave address.
- req_data  in  DATA_W  payload.
- ready  out  1  master idle and cs high; request accepted when req_valid && ready.
- serial_o  out  1  bus drive; idle level 1.
- serial_i  in  1  bus sense, asynchronous to clk.
- ok  out  1  one-cycle pulse: transfer acknowledged.
- fail  out  1  one-cycle pulse: transfer abandoned.
- check_err  out  1  valid with fail: last attempt was NAKed.
- no_answer  out  1  valid with fail: last attempt timed out.

## Operation
- Frame layout, MSB first:
  - start bit 0
  - ADDR_W address bits
  - DATA_W data bits
  - even-parity bit over address and data
  - stop bit 1
- Each bit is held for CLKS_PER_BIT cycles.
- States and transitions:
  - IDLE → START on acceptance; address, data and parity are latched at that point.
  - START → ADDR → DATA → PAR → STOP → WAIT_RSP.
  - WAIT_RSP → RSP on a synchronised 0 seen within TIMEOUT cycles; otherwise → RETRY_CHK.
  - RSP: sample the status bit at the middle of the bit following the start bit. 1 → DONE_OK; 0 → RETRY_CHK.
  - RETRY_CHK: if attempts < MAX_RETRY+1, go to START; otherwise go to DONE_FAIL.
  - DONE_OK and DONE_FAIL pulse their outputs, then return to IDLE.
- serial_i passes through a 2-flop synchroniser before use.
- Reset values:
  - state IDLE
  - serial_o 1
  - ready 0 until the first cycle out of reset with cs high
  - ok, fail, check_err, no_answer all 0
- Boundary conditions:
  - Asserting reset mid-frame forces serial_o to 1 immediately and abandons the transfer; no status is reported.
  - Dropping cs mid-transfer has no effect; the transfer runs to completion.
  - req_valid while busy is ignored (ready is 0).
  - serial_i activity outside WAIT_RSP/RSP is ignored.
  - The attempt counter is wide enough for MAX_RETRY+1.

## Timing
- ready falls the cycle after acceptance.
- serial_o goes to 0 one cycle after acceptance.
- Frame length F = (ADDR_W+DATA_W+3)×CLKS_PER_BIT cycles.
- Response detection adds 2 cycles of synchroniser latency.
- The timeout counter starts in the first WAIT_RSP cycle.
- ok or fail asserts exactly one cycle. check_err and no_answer are meaningful only in the fail cycle and are 0 otherwise.
- ready reasserts the cycle after ok or fail.
- Retries begin the cycle after RETRY_CHK, with no idle gap beyond one stop-bit time.

## Configuration
- SERIAL_BUS_MASTER_RETRY_EN defined: retry behaviour as described above.
- Undefined: MAX_RETRY is ignored. The first NAK or timeout goes straight to DONE_FAIL. The attempt counter logic is removed.

## Structure
- Package serial_bus_pkg holds:
  - state enum
  - START_BIT, STOP_BIT and IDLE_LEVEL constants
  - RSP_ACK/RSP_NAK codes
  - parity function shared with the slaves
- Sub-module serial_bit_tick: CLKS_PER_BIT counter that produces bit-end and mid-bit strobes. It is restarted on frame start and on response start-bit detection.

## Test plan
Defaults for all scenarios: ADDR_W=8, DATA_W=16, CLKS_PER_BIT=4, TIMEOUT=64, MAX_RETRY=2.
- Request addr 0x03, data 0xA5C3; slave ACKs → serial_o carries 0,03,A5C3,parity 0,1 over 108 cycles; ok pulses once; ready returns.
- Addr 0x01, data 0x0001; slave NAKs twice then ACKs → three full frames sent; ok pulses; no fail.
- Slave never answers → three frames, each followed by a 64-cycle wait; then fail, no_answer=1, check_err=0. Without the macro: one frame, then fail.
- Slave always NAKs → fail with check_err=1 after the third frame.
- Assert reset mid-DATA → serial_o=1 the same cycle; no ok/fail; a subsequent request completes normally.
- cs=0 with req_valid=1 → ready=0, serial_o stays 1; raising cs → request accepted the next cycle.
